// File: rtl/gamma_pkg.sv
// Shared widths and FSM state encoding for the gamma LUT controller.
package gamma_pkg;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned LUT_DEPTH = 256;
    localparam int unsigned CFG_AW    = 8;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } gamma_state_e;
endpackage

// File: rtl/gamma_lut_bank.sv
// Two LUT banks in one array: one write port, one registered read port with identity bypass.
module gamma_lut_bank #(
    parameter int unsigned DATA_W    = gamma_pkg::DATA_W,
    parameter int unsigned LUT_DEPTH = gamma_pkg::LUT_DEPTH,
    localparam int unsigned AW       = $clog2(LUT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sel,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_bypass,
    input  logic [DATA_W-1:0] bypass_data,
    output logic [DATA_W-1:0] rd_data
);
    // Bank select is the MSB of the combined address; contents are never reset.
    logic [DATA_W-1:0] mem [2*LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_sel, wr_addr}] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_bypass) begin
            rd_data <= bypass_data;
        end else begin
            rd_data <= mem[{rd_sel, rd_addr}];
        end
    end
endmodule

// File: rtl/gamma_lut_ctrl.sv
// Gamma LUT pixel mapper with double-buffered tables swapped only during vertical blanking.
module gamma_lut_ctrl #(
    parameter int unsigned DATA_W    = gamma_pkg::DATA_W,
    parameter int unsigned LUT_DEPTH = gamma_pkg::LUT_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           per_img_vsync,
    input  logic                           per_img_href,
    input  logic [DATA_W-1:0]              per_img_gray,
    input  logic                           cfg_wr_en,
    input  logic [gamma_pkg::CFG_AW-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]              cfg_data,
    input  logic                           cfg_commit,
    output logic                           cfg_ready,
    output logic                           post_img_vsync,
    output logic                           post_img_href,
    output logic [DATA_W-1:0]              post_img_gray,
    output logic [gamma_pkg::CNT_W-1:0]    swap_cnt
);
    import gamma_pkg::*;

    localparam int unsigned AW = $clog2(LUT_DEPTH);

    gamma_state_e state_q, state_d;
    logic         bank_sel_q;
    logic         lut_valid_q;
    logic         wr_c;
    logic         swap_c;

    // Next-state: writes/commit accepted only in IDLE; swap waits for vsync low.
    always_comb begin
        state_d = state_q;
        wr_c    = 1'b0;
        swap_c  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_c = cfg_wr_en;
                if (cfg_commit) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!per_img_vsync) begin
                    swap_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cfg_ready      <= 1'b1;
            bank_sel_q     <= 1'b0;
            lut_valid_q    <= 1'b0;
            swap_cnt       <= '0;
            post_img_vsync <= 1'b0;
            post_img_href  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cfg_ready      <= (state_d == IDLE);
            post_img_vsync <= per_img_vsync;
            post_img_href  <= per_img_href;
            if (swap_c) begin
                bank_sel_q  <= ~bank_sel_q;
                lut_valid_q <= 1'b1;
                swap_cnt    <= swap_cnt + CNT_W'(1);
            end
        end
    end

    gamma_lut_bank #(
        .DATA_W    (DATA_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_c),
        .wr_sel      (~bank_sel_q),
        .wr_addr     (AW'(cfg_addr)),
        .wr_data     (cfg_data),
        .rd_sel      (bank_sel_q),
        .rd_addr     (AW'(per_img_gray)),
        .rd_bypass   (~lut_valid_q),
        .bypass_data (per_img_gray),
        .rd_data     (post_img_gray)
    );
endmodule
